// File: rtl/dcpu_int_queue.sv
`default_nettype none
// dcpu_int_queue: arbitrates software and hardware interrupt messages into a FIFO
// ahead of the DCPU-16 dispatch logic, handling IAQ hold, IA=0 discard and catch-fire.
module dcpu_int_queue #(
  parameter int DEPTH = 256,
  parameter int N_HW  = 4
) (
  input  logic                     CORE_CLK,
  input  logic                     RESET_N,
  input  logic                     SW_REQ,
  input  logic [15:0]              SW_MSG,
  output logic                     SW_ACK,
  input  logic [N_HW-1:0]          HW_REQ,
  input  logic [16*N_HW-1:0]       HW_MSG,
  output logic [N_HW-1:0]          HW_ACK,
  input  logic                     IAQ,
  input  logic                     IA_ZERO,
  output logic                     INT_VALID,
  output logic [15:0]              INT_MSG,
  input  logic                     INT_TAKE,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FIRE
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          fire;

  logic          grant;
  logic [15:0]   gnt_msg;
  logic          head_valid;
  logic          full;
  logic          pop;
  logic          flush;
  logic          accept;
  logic          wr;
  logic          overflow;
  logic          drop;

  // Fixed priority: software first, then hardware devices in index order.
  always_comb begin
    SW_ACK  = 1'b0;
    HW_ACK  = '0;
    grant   = 1'b0;
    gnt_msg = 16'h0000;
    if (RESET_N) begin
      if (SW_REQ) begin
        SW_ACK  = 1'b1;
        grant   = 1'b1;
        gnt_msg = SW_MSG;
      end else begin
        for (int i = 0; i < N_HW; i++) begin
          if (HW_REQ[i] && !grant) begin
            HW_ACK[i] = 1'b1;
            grant     = 1'b1;
            gnt_msg   = HW_MSG[16*i +: 16];
          end
        end
      end
    end
  end

  assign head_valid = (cnt != '0) && !IAQ && !IA_ZERO && !fire;
  assign full       = (cnt == FULL_CNT);
  assign pop        = head_valid && INT_TAKE;
  assign flush      = IA_ZERO && !IAQ && !fire && (cnt != '0);
  assign drop       = pop || flush;

  // A granted message is always acked; it is only stored when IA is live and
  // there is room (a same-cycle pop frees the slot being written).
  assign accept     = grant && !IA_ZERO && !fire;
  assign wr         = accept && (!full || pop);
  assign overflow   = accept && full && !pop;

  always_ff @(posedge CORE_CLK) begin
    if (!RESET_N) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      fire <= 1'b0;
    end else begin
      if (wr)
        wp <= wp + 1'b1;
      if (drop)
        rp <= rp + 1'b1;
      if (overflow)
        fire <= 1'b1;
      case ({wr, drop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CORE_CLK) begin
    if (wr)
      mem[wp] <= gnt_msg;
  end

  assign INT_VALID = RESET_N && head_valid;
  assign INT_MSG   = mem[rp];
  assign COUNT     = RESET_N ? cnt : '0;
  assign FIRE      = RESET_N && fire;

endmodule
`default_nettype wire

// File: tb/tb_dcpu_int_queue.sv
`default_nettype none
// Randomized and directed bench for dcpu_int_queue against a queue-based reference model.
module tb_dcpu_int_queue;

  localparam int DEPTH = 256;
  localparam int N_HW  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, sw_req, sw_ack, iaq, ia_zero, take, int_valid, fire;
  logic [15:0]       sw_msg, int_msg;
  logic [N_HW-1:0]   hw_req, hw_ack;
  logic [16*N_HW-1:0] hw_msg;
  logic [CW-1:0]     count;

  dcpu_int_queue #(.DEPTH(DEPTH), .N_HW(N_HW)) dut (
    .CORE_CLK(clk), .RESET_N(rst_n),
    .SW_REQ(sw_req), .SW_MSG(sw_msg), .SW_ACK(sw_ack),
    .HW_REQ(hw_req), .HW_MSG(hw_msg), .HW_ACK(hw_ack),
    .IAQ(iaq), .IA_ZERO(ia_zero),
    .INT_VALID(int_valid), .INT_MSG(int_msg), .INT_TAKE(take),
    .COUNT(count), .FIRE(fire)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] mq [$];
  bit          mfire = 1'b0;
  int          last_winner = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    return rst_n && (mq.size() != 0) && !iaq && !ia_zero && !mfire;
  endfunction

  // -1 = no grant, 0 = software, i+1 = hardware device i
  function automatic int m_winner();
    if (!rst_n) return -1;
    if (sw_req) return 0;
    for (int i = 0; i < N_HW; i++)
      if (hw_req[i]) return i + 1;
    return -1;
  endfunction

  task automatic eval();
    int w;
    logic [N_HW-1:0] exp_hw;
    #1;
    w = m_winner();
    exp_hw = (w > 0) ? (N_HW'(1) << (w - 1)) : '0;
    chk("sw_ack", sw_ack, (w == 0));
    chk("hw_ack", hw_ack, exp_hw);
    chk("int_valid", int_valid, m_valid());
    chk("count", count, rst_n ? mq.size() : 0);
    chk("fire", fire, rst_n && mfire);
    if (m_valid())
      chk("int_msg", int_msg, mq[0]);
  endtask

  task automatic adv();
    int w, sz;
    bit pop, flush;
    logic [15:0] msg;
    w   = m_winner();
    pop = m_valid() && take;
    sz  = mq.size();
    if (!rst_n) begin
      mq.delete();
      mfire = 1'b0;
    end else begin
      flush = ia_zero && !iaq && !mfire && (sz > 0);
      msg = (w == 0) ? sw_msg : (w > 0 ? hw_msg[16*(w-1) +: 16] : 16'h0);
      if (pop || flush)
        void'(mq.pop_front());
      if (w >= 0 && !ia_zero && !mfire) begin
        if (sz < DEPTH || pop) mq.push_back(msg);
        else mfire = 1'b1;
      end
    end
    last_winner = w;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    eval();
    adv();
    rst_n = 1'b1;
  endtask

  task automatic stim_requests();
    if (sw_req) begin
      if (last_winner == 0) begin
        sw_req = 1'($urandom_range(0, 1));
        sw_msg = 16'($urandom);
      end
    end else if ($urandom_range(0, 3) == 0) begin
      sw_req = 1'b1;
      sw_msg = 16'($urandom);
    end
    for (int i = 0; i < N_HW; i++) begin
      if (hw_req[i]) begin
        if (last_winner == i + 1) begin
          hw_req[i] = 1'($urandom_range(0, 1));
          hw_msg[16*i +: 16] = 16'($urandom);
        end
      end else if ($urandom_range(0, 5) == 0) begin
        hw_req[i] = 1'b1;
        hw_msg[16*i +: 16] = 16'($urandom);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sw_req = 1'b0; sw_msg = '0; hw_req = '0; hw_msg = '0;
    iaq = 1'b0; ia_zero = 1'b0; take = 1'b0;
    @(negedge clk);
    do_reset();
    do_reset();

    // Single software interrupt: accept, deliver next cycle, pop.
    eval();
    chk("rst_count", count, 0);
    chk("rst_fire", fire, 0);
    chk("rst_valid", int_valid, 0);
    sw_req = 1'b1; sw_msg = 16'h1234;
    adv();
    sw_req = 1'b0;
    sw_msg = 16'h0000;
    eval();
    chk("t1_valid", int_valid, 1);
    chk("t1_msg", int_msg, 16'h1234);
    chk("t1_count", count, 1);
    take = 1'b1;
    adv();
    take = 1'b0;
    eval();
    chk("t1_count_after", count, 0);
    chk("t1_valid_after", int_valid, 0);

    // Priority: SW, then HW[1], then HW[3].
    sw_req = 1'b1; sw_msg = 16'hAAAA;
    hw_req = 4'b1010; hw_msg[31:16] = 16'h0001; hw_msg[63:48] = 16'h0003;
    eval();
    chk("t2_sw_first", sw_ack, 1);
    adv();
    sw_req = 1'b0;
    eval();
    chk("t2_hw1", hw_ack, 4'b0010);
    adv();
    hw_req[1] = 1'b0;
    eval();
    chk("t2_hw3", hw_ack, 4'b1000);
    adv();
    hw_req = '0;
    take = 1'b1;
    eval(); chk("t2_pop0", int_msg, 16'hAAAA); adv();
    eval(); chk("t2_pop1", int_msg, 16'h0001); adv();
    eval(); chk("t2_pop2", int_msg, 16'h0003); adv();
    take = 1'b0;

    // Fill to DEPTH under IAQ, then overflow catches fire.
    iaq = 1'b1;
    sw_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sw_msg = 16'(i);
      eval();
      adv();
    end
    sw_req = 1'b0;
    eval();
    chk("t3_valid_held", int_valid, 0);
    chk("t3_full", count, DEPTH);
    sw_req = 1'b1; sw_msg = 16'hFFFF;
    adv();
    sw_req = 1'b0;
    eval();
    chk("t3_fire", fire, 1);
    chk("t3_count_frozen", count, DEPTH);
    hw_req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      adv();
      eval();
    end
    hw_req = '0;
    chk("t3_count_still", count, DEPTH);

    // Full queue with simultaneous pop and write: no fire, pointer wraps.
    do_reset();
    iaq = 1'b1;
    sw_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sw_msg = 16'(i);
      eval();
      adv();
    end
    sw_req = 1'b0;
    iaq = 1'b0; take = 1'b1;
    hw_req = 4'b0001; hw_msg[15:0] = 16'hBEEF;
    eval();
    chk("t4_hw0_ack", hw_ack, 4'b0001);
    chk("t4_first_pop", int_msg, 16'h0000);
    adv();
    hw_req = '0;
    eval();
    chk("t4_no_fire", fire, 0);
    chk("t4_count", count, DEPTH);
    for (int k = 1; k < DEPTH; k++) begin
      adv();
      eval();
    end
    chk("t4_beef_after_wrap", int_msg, 16'hBEEF);
    adv();
    take = 1'b0;

    // IA=0 flush of three entries while a HW request is discarded.
    iaq = 1'b1;
    sw_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      sw_msg = 16'(16'h0101 * i);
      eval();
      adv();
    end
    sw_req = 1'b0;
    iaq = 1'b0; ia_zero = 1'b1;
    hw_req = 4'b0010; hw_msg[31:16] = 16'h5555;
    eval();
    chk("t5_valid", int_valid, 0);
    chk("t5_count3", count, 3);
    chk("t5_hw_ack", hw_ack, 4'b0010);
    adv();
    hw_req = '0;
    eval(); chk("t5_count2", count, 2); adv();
    eval(); chk("t5_count1", count, 1); adv();
    eval(); chk("t5_count0", count, 0);
    ia_zero = 1'b0;

    // Fire, then reset while HW[2] requests.
    iaq = 1'b1;
    sw_req = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      sw_msg = 16'(i);
      adv();
      eval();
    end
    sw_req = 1'b0;
    chk("t6_fire_set", fire, 1);
    adv();
    rst_n = 1'b0;
    hw_req = 4'b0100; hw_msg[47:32] = 16'h2222;
    eval();
    chk("t6_ack_in_reset", hw_ack, 4'b0000);
    adv();
    rst_n = 1'b1;
    eval();
    chk("t6_count_rst", count, 0);
    chk("t6_fire_rst", fire, 0);
    chk("t6_hw2_ack", hw_ack, 4'b0100);
    adv();
    hw_req = '0;
    iaq = 1'b0;
    eval();
    chk("t6_valid", int_valid, 1);
    chk("t6_msg", int_msg, 16'h2222);
    take = 1'b1;
    adv();
    take = 1'b0;

    // Randomized phases alternating drain-heavy and fill-heavy traffic.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      bit fill;
      fill = ((cyc / 1000) % 2) == 1;
      rst_n = !((cyc % 1000 == 0) || ($urandom_range(0, 499) == 0));
      if (fill) begin
        iaq  = ($urandom_range(0, 9) != 0);
        take = ($urandom_range(0, 4) == 0);
      end else begin
        iaq  = ($urandom_range(0, 9) == 0);
        take = ($urandom_range(0, 9) < 6);
      end
      ia_zero = ($urandom_range(0, 29) == 0);
      stim_requests();
      eval();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcpu_int_queue.md
# dcpu_int_queue

Interrupt queue sitting directly upstream of the DCPU-16 core. Collects interrupt messages from the core's software `INT` instruction and from N hardware devices, arbitrates them into a DEPTH-entry FIFO, and presents one message at a time to the core's interrupt-dispatch logic. Implements the DCPU-16 rules for queueing (IAQ), IA=0 discard, and catch-fire on overflow.

## Interface
- `DEPTH`, 256, FIFO entries; power of two, ≥2
- `N_HW`, 4, number of hardware interrupt sources, 1..16
- `CORE_CLK`  in  1  core clock; all state updates on rising edge
- `RESET_N`  in  1  synchronous, active-low reset
- `SW_REQ`  in  1  software interrupt request from core (`INT a`)
- `SW_MSG`  in  16  software interrupt message
- `SW_ACK`  out  1  SW request accepted this cycle
- `HW_REQ`  in  N_HW  per-device interrupt request
- `HW_MSG`  in  16*N_HW  per-device message; device i on bits [16i+15:16i]
- `HW_ACK`  out  N_HW  per-device accept, one-hot or zero
- `IAQ`  in  1  core queueing flag; 1 = hold delivery
- `IA_ZERO`  in  1  core IA register == 0
- `INT_VALID`  out  1  head message available to core
- `INT_MSG`  out  16  head message
- `INT_TAKE`  in  1  core pops head this cycle
- `COUNT`  out  clog2(DEPTH)+1  current occupancy
- `FIRE`  out  1  sticky overflow ("caught fire")

## Operation
- Storage: DEPTH×16 array, write pointer `wp`, read pointer `rp` (clog2(DEPTH) bits, natural wrap), occupancy `cnt`.
- Arbitration: at most one request granted per cycle. Priority: SW_REQ, then HW_REQ[0], ..., HW_REQ[N_HW-1]. Exactly the winner's ACK is high; losers keep REQ/MSG stable and retry. ACKs are combinational from REQ and state.
- Transfer occurs on a rising edge where REQ&ACK=1. Requester may drop REQ or present the next message the following cycle.
- Grant outcomes for the winner:
  - `IA_ZERO`=1 or `FIRE`=1: acked, discarded, no write.
  - `cnt`<DEPTH, or `cnt`==DEPTH with a pop this cycle: acked, written at `wp`, `wp`++.
  - `cnt`==DEPTH, no pop: acked, discarded, `FIRE` set.
- Pop: occurs when `INT_VALID`&`INT_TAKE`; `rp`++. `INT_TAKE` with `INT_VALID`=0 is ignored.
- Flush: when `IA_ZERO`=1, `IAQ`=0, `FIRE`=0 and `cnt`>0, head is discarded (`rp`++) one entry per cycle.
- `cnt` next = `cnt` + write − (pop or flush); simultaneous write and pop leave `cnt` unchanged.
- `INT_VALID` = (`cnt`≠0) & !`IAQ` & !`IA_ZERO` & !`FIRE`. `INT_MSG` = array[`rp`].
- `FIRE` is sticky until `RESET_N`=0; while set no writes, pops or flushes occur; `COUNT` freezes.

## Timing
- Reset (`RESET_N`=0 at rising edge): `wp`=`rp`=0, `cnt`=0, `FIRE`=0. During and after reset: `INT_VALID`=0, `COUNT`=0, `FIRE`=0; `SW_ACK`/`HW_ACK` forced 0 while `RESET_N`=0; `INT_MSG` don't-care while `INT_VALID`=0. Array contents are not reset.
- Reset mid-operation discards all queued entries and clears `FIRE`; pending REQs are granted normally from the first cycle after `RESET_N`=1.
- Enqueue→deliver latency: message accepted at edge k into empty queue shows `INT_VALID`=1, `INT_MSG`=message in cycle after edge k; no same-cycle bypass.
- Back-to-back: one enqueue and one pop per cycle sustained; full throughput at `cnt`==DEPTH if popping.
- `IAQ` and `IA_ZERO` act combinationally on `INT_VALID` in the same cycle.
- Pointer wrap at DEPTH−1→0 is silent; `cnt` distinguishes full from empty.

## Test plan
- Reset, then SW_REQ=1 with SW_MSG=0x1234 for one cycle, IAQ=0, IA_ZERO=0 → SW_ACK=1 that cycle; next cycle INT_VALID=1, INT_MSG=0x1234, COUNT=1; INT_TAKE=1 → COUNT=0, INT_VALID=0.
- SW_REQ and HW_REQ=4'b1010 asserted together with messages 0xAAAA, 0x0001, 0x0003 → ACK order SW, HW[1], HW[3] on three consecutive cycles; pops return 0xAAAA, 0x0001, 0x0003.
- IAQ=1, enqueue 256 messages 0x0000..0x00FF → INT_VALID=0, COUNT=256; one more request with no pop → acked, FIRE=1, COUNT stays 256; further requests acked, COUNT unchanged.
- Full queue (256), IAQ=0, INT_TAKE=1 and HW_REQ[0] same cycle with 0xBEEF → FIRE=0, COUNT=256, 0xBEEF appears as 256th pop after wrap of `wp`.
- Queue holds 3 entries, IA_ZERO=1, IAQ=0 → INT_VALID=0, COUNT goes 3,2,1,0 over three cycles; a concurrent HW_REQ is acked and not stored.
- FIRE=1 with COUNT=256, assert RESET_N=0 for one edge while HW_REQ[2]=1 → HW_ACK=0 during reset, COUNT=0, FIRE=0 after; HW_REQ[2] acked next cycle and delivered.
